// File: rtl/inv_key_schedule_if.sv
// Handshake bundle between the inverse key schedule and its neighbours.
// The key register file side starts a sequence; the inverse-cipher round
// logic side consumes round keys with a valid/ready handshake.
interface inv_key_schedule_if;
  logic         start;
  logic [127:0] key_in;
  logic         out_ready;
  logic         key_valid;
  logic [127:0] key_out;
  logic [3:0]   round_idx;
  logic         busy;
  logic         done;

  modport master (
    output start, key_in, out_ready,
    input  key_valid, key_out, round_idx, busy, done
  );

  modport slave (
    input  start, key_in, out_ready,
    output key_valid, key_out, round_idx, busy, done
  );
endinterface

// File: rtl/inv_key_schedule.sv
// AES-128 inverse key schedule.
// Loaded with the round-10 key, it emits round keys 10 down to 0, one per
// handshake. Between keys it spends four cycles pushing RotWord bytes
// through a single shared forward S-box, then rewinds one round of the
// key expansion using an Rcon that is regenerated in descending order.
module inv_key_schedule (
  input logic               clk,
  input logic               rst,
  inv_key_schedule_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    SUB  = 2'd2
  } state_t;

  // Forward AES S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Combinational forward S-box lookup.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [10:0] base;
    base = 11'd2047 - {x, 3'b000};
    return SBOX_TABLE[base -: 8];
  endfunction

  // Rcon of the previous round: inverse of xtime in GF(2^8).
  function automatic logic [7:0] rcon_prev(input logic [7:0] r);
    return (r >> 1) ^ (r[0] ? 8'h8d : 8'h00);
  endfunction

  state_t       state_r, state_s;
  logic [127:0] key_r, key_s;
  logic [3:0]   round_r, round_s;
  logic [7:0]   rcon_r, rcon_s;
  logic [23:0]  temp_r, temp_s;     // SubWord bytes 0..2; byte 3 used directly
  logic [1:0]   cnt_r, cnt_s;
  logic         done_r, done_s;
  logic         key_valid_r, key_valid_s;
  logic         busy_r, busy_s;

  logic [31:0]  w0_s, w1_s, w2_s, w3_s;
  logic [31:0]  t_s, rot_s, subword_s;
  logic [7:0]   sbox_in_s, sbox_out_s;

  assign w0_s = key_r[127:96];
  assign w1_s = key_r[95:64];
  assign w2_s = key_r[63:32];
  assign w3_s = key_r[31:0];

  // t is the previous round's w3; its rotation feeds the shared S-box.
  assign t_s        = w3_s ^ w2_s;
  assign rot_s      = {t_s[23:0], t_s[31:24]};
  assign sbox_out_s = sbox(sbox_in_s);
  assign subword_s  = {temp_r, sbox_out_s};

  // Select the RotWord byte for the current SUB cycle, MSB first.
  always_comb begin
    sbox_in_s = rot_s[31:24];
    case (cnt_r)
      2'd0:    sbox_in_s = rot_s[31:24];
      2'd1:    sbox_in_s = rot_s[23:16];
      2'd2:    sbox_in_s = rot_s[15:8];
      2'd3:    sbox_in_s = rot_s[7:0];
      default: sbox_in_s = rot_s[31:24];
    endcase
  end

  // Next-state and datapath update for the IDLE/EMIT/SUB sequencer.
  always_comb begin
    state_s = state_r;
    key_s   = key_r;
    round_s = round_r;
    rcon_s  = rcon_r;
    temp_s  = temp_r;
    cnt_s   = cnt_r;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          key_s   = bus.key_in;
          round_s = 4'd10;
          rcon_s  = 8'h36;
          state_s = EMIT;
        end else begin
          state_s = IDLE;
        end
      end
      EMIT: begin
        if (bus.out_ready) begin
          if (round_r == 4'd0) begin
            state_s = IDLE;
            done_s  = 1'b1;
          end else begin
            state_s = SUB;
            cnt_s   = 2'd0;
          end
        end else begin
          state_s = EMIT;
        end
      end
      SUB: begin
        case (cnt_r)
          2'd0: begin
            temp_s[23:16] = sbox_out_s;
            cnt_s         = 2'd1;
          end
          2'd1: begin
            temp_s[15:8] = sbox_out_s;
            cnt_s        = 2'd2;
          end
          2'd2: begin
            temp_s[7:0] = sbox_out_s;
            cnt_s       = 2'd3;
          end
          2'd3: begin
            key_s   = {w0_s ^ subword_s ^ {rcon_r, 24'h000000},
                       w1_s ^ w0_s,
                       w2_s ^ w1_s,
                       w3_s ^ w2_s};
            round_s = round_r - 4'd1;
            rcon_s  = rcon_prev(rcon_r);
            cnt_s   = 2'd0;
            state_s = EMIT;
          end
          default: begin
            cnt_s   = 2'd0;
            state_s = IDLE;
          end
        endcase
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Status outputs are decoded from the next state so they leave registers.
  always_comb begin
    key_valid_s = (state_s == EMIT);
    busy_s      = (state_s != IDLE);
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      key_r       <= 128'd0;
      round_r     <= 4'd0;
      rcon_r      <= 8'h36;
      temp_r      <= 24'd0;
      cnt_r       <= 2'd0;
      done_r      <= 1'b0;
      key_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      key_r       <= key_s;
      round_r     <= round_s;
      rcon_r      <= rcon_s;
      temp_r      <= temp_s;
      cnt_r       <= cnt_s;
      done_r      <= done_s;
      key_valid_r <= key_valid_s;
      busy_r      <= busy_s;
    end
  end

  assign bus.key_valid = key_valid_r;
  assign bus.key_out   = key_r;
  assign bus.round_idx = round_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;

endmodule

// File: tb/tb_inv_key_schedule.sv
// Scoreboard bench for inv_key_schedule. Expected round keys come from a
// word-level inverse key expansion using an S-box derived from GF(2^8)
// inversion plus the affine map; a negedge monitor checks every presented key.
module tb_inv_key_schedule;

  typedef struct {
    logic [3:0]   rnd;
    logic [127:0] key;
  } exp_t;

  localparam logic [127:0] FIPS_K10 = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;
  localparam logic [127:0] FIPS_K9  = 128'hac7766f3_19fadc21_28d12941_575c006e;
  localparam logic [127:0] FIPS_K0  = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;

  logic clk;
  logic rst;
  inv_key_schedule_if bus ();

  inv_key_schedule dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int           vectors;
  int           miscompares;
  exp_t         q[$];
  logic [127:0] got_keys [0:10];
  logic [7:0]   sb [0:255];
  logic [7:0]   rc [0:9];
  bit           done_exp;

  // ---------------- reference model ----------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = xtime(aa);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic build_tables();
    logic [7:0] inv;
    logic [7:0] r;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    r = 8'h01;
    for (int j = 0; j < 10; j++) begin
      rc[j] = r;
      r = xtime(r);
    end
  endtask

  function automatic logic [31:0] subrot(input logic [31:0] w);
    logic [31:0] rw;
    rw = {w[23:0], w[31:24]};
    return {sb[rw[31:24]], sb[rw[23:16]], sb[rw[15:8]], sb[rw[7:0]]};
  endfunction

  // Rewind the forward expansion w[i] = w[i-4] ^ f(w[i-1]) from w[40..43].
  task automatic push_model(input logic [127:0] k10);
    logic [31:0] w [0:43];
    logic [31:0] tmp;
    exp_t e;
    w[40] = k10[127:96]; w[41] = k10[95:64]; w[42] = k10[63:32]; w[43] = k10[31:0];
    for (int i = 43; i >= 4; i--) begin
      tmp = w[i-1];
      if (i % 4 == 0) tmp = subrot(tmp) ^ {rc[i/4 - 1], 24'h000000};
      w[i-4] = w[i] ^ tmp;
    end
    for (int r = 10; r >= 0; r--) begin
      e.rnd = 4'(r);
      e.key = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      q.push_back(e);
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare every presented key against the scoreboard head.
  always @(negedge clk) begin
    if (rst) begin
      done_exp = 1'b0;
    end else begin
      chk("done", 128'(bus.done), 128'(done_exp));
      done_exp = 1'b0;
      if (bus.key_valid) begin
        if (q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_key: got round %0d key %h, nothing expected", bus.round_idx, bus.key_out);
        end else begin
          chk("round_idx", 128'(bus.round_idx), 128'(q[0].rnd));
          chk("key_out", bus.key_out, q[0].key);
          if (bus.out_ready) begin
            if (bus.round_idx <= 4'd10) got_keys[bus.round_idx] = bus.key_out;
            if (bus.round_idx == 4'd0) done_exp = 1'b1;
            void'(q.pop_front());
          end
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_start(input logic [127:0] k);
    bus.key_in = k;
    bus.start  = 1'b1;
    push_model(k);
    tick();
    bus.start  = 1'b0;
  endtask

  task automatic wait_for_round(input logic [3:0] r);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (bus.key_valid && bus.round_idx == r) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_round: got timeout expected round %0d", r);
    end
  endtask

  task automatic wait_done(input int budget, input bit rnd_ready, output int n);
    bit ok;
    ok = 1'b0;
    n = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      n++;
      if (bus.done) begin
        ok = 1'b1;
        break;
      end
      if (rnd_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
    end
    bus.out_ready = 1'b1;
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_done: got timeout expected done within %0d cycles", budget);
    end
  endtask

  initial begin
    int n;
    bit ok;
    logic [127:0] ka;
    logic [127:0] kb;

    vectors = 0;
    miscompares = 0;
    done_exp = 1'b0;
    build_tables();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.key_in = 128'd0;
    bus.out_ready = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst_key_valid", 128'(bus.key_valid), 128'd0);
    chk("rst_busy", 128'(bus.busy), 128'd0);
    chk("rst_done", 128'(bus.done), 128'd0);
    chk("rst_key_out", bus.key_out, 128'd0);
    chk("rst_round_idx", 128'(bus.round_idx), 128'd0);
    rst = 1'b0;
    tick();

    // FIPS-197 A.1 with latency checks and done timing
    bus.out_ready = 1'b1;
    issue_start(FIPS_K10);
    chk("lat_start_valid", 128'(bus.key_valid), 128'd1);
    chk("lat_start_busy", 128'(bus.busy), 128'd1);
    n = 0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      n++;
      if (n >= 1 && n <= 4) chk("lat_gap_low", 128'(bus.key_valid), 128'd0);
      if (n == 5) chk("lat_gap_high", 128'(bus.key_valid), 128'd1);
      if (bus.done) begin
        ok = 1'b1;
        break;
      end
    end
    chk("done_seen", 128'(ok), 128'd1);
    chk("done_cycle", 128'(n), 128'd51);
    tick();
    chk("done_pulse_width", 128'(bus.done), 128'd0);
    chk("idle_busy", 128'(bus.busy), 128'd0);
    chk("fips_k10", got_keys[10], FIPS_K10);
    chk("fips_k9", got_keys[9], FIPS_K9);
    chk("fips_k0", got_keys[0], FIPS_K0);

    // Backpressure at round 5
    got_keys[0] = 128'd0;
    issue_start(FIPS_K10);
    wait_for_round(4'd5);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("bp_valid", 128'(bus.key_valid), 128'd1);
      chk("bp_round", 128'(bus.round_idx), 128'd5);
    end
    bus.out_ready = 1'b1;
    wait_done(200, 1'b0, n);
    chk("bp_k0", got_keys[0], FIPS_K0);

    // Start while busy is ignored
    ka = {$urandom, $urandom, $urandom, $urandom};
    kb = ~ka;
    tick();
    issue_start(ka);
    wait_for_round(4'd7);
    chk("ign_busy", 128'(bus.busy), 128'd1);
    bus.key_in = kb;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done(200, 1'b0, n);
    tick();
    chk("ign_idle_after", 128'(bus.busy), 128'd0);
    chk("ign_no_valid", 128'(bus.key_valid), 128'd0);

    // Reset during SUB of round 3
    issue_start(FIPS_K10);
    wait_for_round(4'd3);
    tick();
    tick();
    rst = 1'b1;
    q.delete();
    tick();
    chk("mid_rst_valid", 128'(bus.key_valid), 128'd0);
    chk("mid_rst_busy", 128'(bus.busy), 128'd0);
    chk("mid_rst_done", 128'(bus.done), 128'd0);
    chk("mid_rst_key", bus.key_out, 128'd0);
    chk("mid_rst_round", 128'(bus.round_idx), 128'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mid_rst_no_done", 128'(bus.done), 128'd0);
    end

    // Fresh FIPS run, then back-to-back all-zero key
    got_keys[0] = 128'd0;
    got_keys[9] = 128'd0;
    issue_start(FIPS_K10);
    wait_for_round(4'd0);
    bus.key_in = 128'd0;
    bus.start = 1'b1;
    push_model(128'd0);
    tick();
    chk("b2b_done", 128'(bus.done), 128'd1);
    chk("b2b_fips_k0", got_keys[0], FIPS_K0);
    chk("b2b_fips_k9", got_keys[9], FIPS_K9);
    tick();
    bus.start = 1'b0;
    chk("b2b_valid", 128'(bus.key_valid), 128'd1);
    chk("b2b_round", 128'(bus.round_idx), 128'd10);
    chk("b2b_zero_key", bus.key_out, 128'd0);
    wait_done(200, 1'b0, n);

    // Random keys with random backpressure
    for (int r = 0; r < 4; r++) begin
      tick();
      issue_start({$urandom, $urandom, $urandom, $urandom});
      wait_done(3000, 1'b1, n);
    end
    tick();
    tick();
    chk("queue_drained", 128'(q.size()), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
